// File: rtl/mem_if_pkg.sv
// Shared types for the 16x32 valid/ready memory interface.
// Command payload, widths and initiator state encoding.
package mem_if_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              rnw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP
  } init_state_t;

endpackage

// File: rtl/mem_req_initiator_cmd_fifo.sv
// Command FIFO for the memory request initiator.
// First-word-fall-through head, registered count drives full/empty.
module cmd_fifo
  import mem_if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  mem_cmd_t               data_i,
  input  logic                   pop_i,
  output mem_cmd_t               data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  mem_cmd_t        mem_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            push;
  logic            pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  // Pointer and occupancy update; full refuses push even alongside a pop.
  always_comb begin
    push  = push_i && !full_o;
    pop   = pop_i && !empty_o;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + PW'(1);
    if (pop)  rd_d = rd_q + PW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage; contents are don't-care while not counted.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/mem_req_initiator.sv
// Memory request initiator: queues commands, issues them one at a time,
// returns in-order responses with a per-request timeout.
module mem_req_initiator
  import mem_if_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_rnw_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              req_o,
  output logic              req_rnw_o,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [DATA_W-1:0] req_wdata_o,
  input  logic              req_ready_i,
  input  logic [DATA_W-1:0] req_rdata_i,
  output logic              rsp_valid_o,
  output logic              rsp_rnw_o,
  output logic [ADDR_W-1:0] rsp_addr_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_timeout_o,
  output logic              busy_o
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  mem_cmd_t                  cmd_in;
  mem_cmd_t                  head;
  logic                      full;
  logic                      empty;
  logic                      pop;
  logic [$clog2(CMD_DEPTH):0] fifo_cnt;

  init_state_t       state_q, state_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              req_q, req_d;
  logic              req_rnw_q, req_rnw_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_rnw_q, rsp_rnw_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_tmo_q, rsp_tmo_d;

  assign cmd_in = '{rnw: cmd_rnw_i, addr: cmd_addr_i, wdata: cmd_wdata_i};

  cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (cmd_valid_i),
    .data_i  (cmd_in),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_cnt)
  );

  assign cmd_ready_o   = !full;
  assign busy_o        = (state_q != IDLE) || (fifo_cnt != '0);
  assign req_o         = req_q;
  assign req_rnw_o     = req_rnw_q;
  assign req_addr_o    = req_addr_q;
  assign req_wdata_o   = req_wdata_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rnw_o     = rsp_rnw_q;
  assign rsp_addr_o    = rsp_addr_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_timeout_o = rsp_tmo_q;

  // Issue / wait / gap sequencing; ready beats timeout in the same cycle.
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    req_d       = req_q;
    req_rnw_d   = req_rnw_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rnw_d   = rsp_rnw_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_tmo_d   = rsp_tmo_q;
    pop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop         = 1'b1;
          req_d       = 1'b1;
          req_rnw_d   = head.rnw;
          req_addr_d  = head.addr;
          req_wdata_d = head.wdata;
          tmo_d       = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (req_ready_i) begin
          req_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rnw_d   = req_rnw_q;
          rsp_addr_d  = req_addr_q;
          rsp_rdata_d = req_rnw_q ? req_rdata_i : '0;
          rsp_tmo_d   = 1'b0;
          state_d     = GAP;
        end else if (tmo_q == TMO_LAST) begin
          req_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rnw_d   = req_rnw_q;
          rsp_addr_d  = req_addr_q;
          rsp_rdata_d = '0;
          rsp_tmo_d   = 1'b1;
          state_d     = GAP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, timeout counter and registered request/response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      req_q       <= 1'b0;
      req_rnw_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rnw_q   <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      req_q       <= req_d;
      req_rnw_q   <= req_rnw_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rnw_q   <= rsp_rnw_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_tmo_q   <= rsp_tmo_d;
    end
  end

endmodule

// File: doc/mem_req_initiator.md
# mem_req_initiator

Request initiator for the 16x32 valid/ready memory interface. Accepts read/write commands from a producer into a small command FIFO, drives them one at a time onto the memory request port, waits for the responder's ready pulse, and returns an in-order response (read data or write acknowledgement). A per-request timeout stops the initiator hanging on an unresponsive memory.

## Interface
- CMD_DEPTH, 4, command FIFO entries (power of two, ≥2)
- TIMEOUT, 15, max cycles req_o stays high awaiting ready (≥1)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- cmd_valid_i  in  1  producer command valid
- cmd_ready_o  out  1  FIFO not full; command accepted on valid&&ready at rising edge
- cmd_rnw_i  in  1  1 = read, 0 = write
- cmd_addr_i  in  4  word address
- cmd_wdata_i  in  32  write data
- req_o  out  1  memory request valid, held until ready or timeout
- req_rnw_o  out  1  read-not-write
- req_addr_o  out  4  address
- req_wdata_o  out  32  write data
- req_ready_i  in  1  single-cycle accept pulse from memory
- req_rdata_i  in  32  read data, valid in the req_ready_i cycle
- rsp_valid_o  out  1  one-cycle response pulse, no backpressure
- rsp_rnw_o  out  1  rnw of completed command
- rsp_addr_o  out  4  address of completed command
- rsp_rdata_o  out  32  read data; 0 for writes and timeouts
- rsp_timeout_o  out  1  qualifies rsp_valid_o: request timed out
- busy_o  out  1  FSM not IDLE or FIFO non-empty

## Operation
- FIFO: CMD_DEPTH entries of {rnw, addr, wdata}; cmd_ready_o = !full (registered count). Push and pop in the same cycle both take effect; when full, push refused even if a pop occurs that cycle.
- FSM states IDLE, REQ, GAP.
- IDLE: if FIFO non-empty → pop head, load req_rnw_o/addr_o/wdata_o, req_o←1, tmo_cnt←0, → REQ.
- REQ: req_o and all req_* fields stable.
  - req_ready_i=1 → req_o←0, rsp_valid_o←1, rsp_rdata_o←(rnw ? req_rdata_i : 0), rsp_timeout_o←0 → GAP.
  - else tmo_cnt==TIMEOUT-1 → req_o←0, rsp_valid_o←1, rsp_timeout_o←1, rsp_rdata_o←0 → GAP.
  - else tmo_cnt←tmo_cnt+1.
  - ready and timeout in same cycle: ready wins.
- GAP: req_o low exactly one cycle (lets responder clear its delay counter) → IDLE.
- req_ready_i outside REQ ignored.
- tmo_cnt width $clog2(TIMEOUT); never wraps.
- Responses strictly in command order; rsp_rnw_o/rsp_addr_o copy the completed request's fields.
- Reset mid-operation: FIFO emptied, FSM→IDLE, in-flight command dropped with no response.

## Timing
- Reset values: cmd_ready_o=1 (after reset release), req_o=0, req_rnw_o=0, req_addr_o=0, req_wdata_o=0, rsp_valid_o=0, rsp_rnw_o=0, rsp_addr_o=0, rsp_rdata_o=0, rsp_timeout_o=0, busy_o=0.
- All outputs registered except cmd_ready_o and busy_o (decoded from registered state/count).
- Command accepted at edge E into empty FIFO with FSM IDLE → req_o high after edge E+1.
- req_ready_i high in cycle C → req_o low and rsp_valid_o high after edge ending C; rsp_valid_o low one cycle later.
- Minimum issue period: ready cycle + GAP + IDLE → next req_o two cycles after req_o falls.
- Timeout: req_o high exactly TIMEOUT cycles.

## Structure
- Package mem_if_pkg: ADDR_W=4, DATA_W=32, mem_cmd_t struct {rnw, addr, wdata}, init_state_t enum {IDLE, REQ, GAP}.
- Sub-module cmd_fifo (parameterised depth, mem_cmd_t payload, full/empty/count); FSM, timeout counter and response regs in top.

## Test plan
- Write 0xDEADBEEF to addr 3 then read addr 3, memory delay 3 → two responses in order; second rsp_rnw_o=1, rsp_addr_o=3, rsp_rdata_o=0xDEADBEEF, rsp_timeout_o=0.
- Hold req_ready_i=0, push 6 back-to-back commands → exactly 5 accepted (1 in flight + 4 queued), cmd_ready_o low from 6th, busy_o=1.
- Never assert req_ready_i, TIMEOUT=15 → req_o high exactly 15 cycles, then rsp_valid_o with rsp_timeout_o=1, rsp_rdata_o=0; next command issues after GAP.
- Ready pulse in 15th req_o cycle → normal response, rsp_timeout_o=0.
- Assert reset during REQ with 3 commands queued → all outputs at reset values next cycle, no response emitted, FIFO empty, busy_o=0.
- Random memory delays 1–7: 16 writes (data = addr*0x01010101) then 16 reads → 32 in-order responses, read data matches, no timeouts, req_* stable whenever req_o high.
